tc_dual_port_ram: RTL

//  Two-port synchronous RAM, successor to the single-port RAM component.
//  Two independent load/save ports share one array; read latency is configurable.
//  On reset release, a hardware sweep zeroes every word.

---
 rtl/tc_dual_port_ram.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/tc_dual_port_ram.sv
// tc_dual_port_ram
//   Two-port synchronous RAM sharing one array. After reset is released, a
//   hardware sweep writes zero to every word before requests are accepted.
//   Read data returns READ_LATENCY cycles after the sampled load, fully pipelined.
//   Optional build macro: TC_DPRAM_BYPASS_EN
//     defined   -> cross-port read-during-write returns the newly written word
//     undefined -> cross-port read-during-write returns the pre-write word
//   dbg_state exposes the sweep FSM encoding (0 RESET, 1 CLEAR, 2 READY).
module tc_dual_port_ram #(
  parameter int BIT_WIDTH    = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEM_WORDS    = 65536,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  input  logic                  a_load,
  input  logic                  a_save,
  input  logic [ADDR_WIDTH-1:0] a_address,
  input  logic [BIT_WIDTH-1:0]  a_in,
  output logic [BIT_WIDTH-1:0]  a_out,
  output logic                  a_valid,
  input  logic                  b_load,
  input  logic                  b_save,
  input  logic [ADDR_WIDTH-1:0] b_address,
  input  logic [BIT_WIDTH-1:0]  b_in,
  output logic [BIT_WIDTH-1:0]  b_out,
  output logic                  b_valid,
  output logic [1:0]            dbg_state
);

  // Request/response protocol: there is no ready input. A load or save is
  // accepted on any posedge where busy=0 and dropped (no side effect, no
  // valid pulse) where busy=1. Every accepted load produces exactly one
  // one-cycle *_valid pulse READ_LATENCY edges later; *_out is 0 whenever
  // *_valid is 0. Loads to addresses >= MEM_WORDS still pulse valid with 0.

  localparam int CTR_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS);
  localparam logic [CTR_W-1:0]    LAST_IDX  = CTR_W'(MEM_WORDS - 1);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;

  logic [BIT_WIDTH-1:0] mem [MEM_WORDS];

  logic                 ready;
  logic                 clear_we;
  logic                 a_inr, b_inr;
  logic                 a_rd, b_rd;
  logic                 a_we, b_we;
  logic [CTR_W-1:0]     a_idx, b_idx;
  logic [BIT_WIDTH-1:0] a_rd_data, b_rd_data;

  logic [BIT_WIDTH-1:0] a_pipe_d [READ_LATENCY+1];
  logic [BIT_WIDTH-1:0] b_pipe_d [READ_LATENCY+1];
  logic [READ_LATENCY:0] a_pipe_v;
  logic [READ_LATENCY:0] b_pipe_v;

  // Sweep FSM state and counter; reset aborts any sweep in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RESET;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

  // Next state: leave RESET on the first clock after release, sweep every
  // word once in CLEAR, then stay in READY until the next reset.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    case (state_q)
      ST_RESET: begin
        state_d = ST_CLEAR;
        ctr_d   = '0;
      end
      ST_CLEAR: begin
        ctr_d = ctr_q + CTR_W'(1);
        if (ctr_q == LAST_IDX) begin
          state_d = ST_READY;
          ctr_d   = '0;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_RESET;
        ctr_d   = '0;
      end
    endcase
  end

  assign ready     = (state_q == ST_READY);
  assign busy      = ~ready;
  assign clear_we  = (state_q == ST_CLEAR);
  assign dbg_state = state_q;

  // Address qualification: unsigned compare against the implemented depth.
  assign a_inr = ({1'b0, a_address} < MEM_LIMIT);
  assign b_inr = ({1'b0, b_address} < MEM_LIMIT);
  assign a_idx = a_address[CTR_W-1:0];
  assign b_idx = b_address[CTR_W-1:0];

  assign a_rd = ready & a_load;
  assign b_rd = ready & b_load;
  assign a_we = ready & a_save & a_inr;
  assign b_we = ready & b_save & b_inr;

`ifdef TC_DPRAM_BYPASS_EN
  logic same_addr;
  assign same_addr = (a_address == b_address);

  // Read data with cross-port forwarding: the reader sees the word that will
  // be stored at this edge, which is port A's data when both ports write.
  always_comb begin
    a_rd_data = '0;
    b_rd_data = '0;
    if (a_inr) a_rd_data = mem[a_idx];
    if (b_inr) b_rd_data = mem[b_idx];
    if (b_we && same_addr) a_rd_data = a_we ? a_in : b_in;
    if (a_we && same_addr) b_rd_data = a_in;
  end
`else
  // Read data is the array content before this edge's writes (read-first).
  always_comb begin
    a_rd_data = '0;
    b_rd_data = '0;
    if (a_inr) a_rd_data = mem[a_idx];
    if (b_inr) b_rd_data = mem[b_idx];
  end
`endif

  // Array writes: the sweep owns the array while clearing; otherwise port B
  // writes first so that port A's write lands last and wins a collision.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[ctr_q] <= '0;
    end else begin
      if (b_we) mem[b_idx] <= b_in;
      if (a_we) mem[a_idx] <= a_in;
    end
  end

  // Port A read pipeline: stage 0 captures data at the sampling edge, the
  // last stage drives the output; reset flushes every stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_pipe_v <= '0;
      for (int i = 0; i <= READ_LATENCY; i++) a_pipe_d[i] <= '0;
    end else begin
      a_pipe_v    <= {a_pipe_v[READ_LATENCY-1:0], a_rd};
      a_pipe_d[0] <= a_rd ? a_rd_data : '0;
      for (int i = 1; i <= READ_LATENCY; i++) a_pipe_d[i] <= a_pipe_d[i-1];
    end
  end

  // Port B read pipeline, identical to port A.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_pipe_v <= '0;
      for (int i = 0; i <= READ_LATENCY; i++) b_pipe_d[i] <= '0;
    end else begin
      b_pipe_v    <= {b_pipe_v[READ_LATENCY-1:0], b_rd};
      b_pipe_d[0] <= b_rd ? b_rd_data : '0;
      for (int i = 1; i <= READ_LATENCY; i++) b_pipe_d[i] <= b_pipe_d[i-1];
    end
  end

  assign a_valid = a_pipe_v[READ_LATENCY];
  assign b_valid = b_pipe_v[READ_LATENCY];
  assign a_out   = a_valid ? a_pipe_d[READ_LATENCY] : '0;
  assign b_out   = b_valid ? b_pipe_d[READ_LATENCY] : '0;

endmodule
